// File: rtl/n3_pwl_array_if.sv
// n3_pwl_array_if
//   Bundles the data/control bus of the multi-lane piecewise-linear activation
//   unit. clk and rst are deliberately not part of the bundle.
//
//   Signals (direction as seen by the unit, i.e. the slave modport):
//     i_en         in   pipeline advance; low freezes every stage register
//     i_valid      in   input vector valid
//     i_mode       in   0/3 = PWL, 1 = identity, 2 = ReLU
//     i_X          in   NUM_LANES packed lanes, lane k at [k*W +: W]
//     i_load_coef  in   coefficient table write strobe
//     i_coef_addr  in   segment to write
//     i_coef       in   {a, b}, a in the upper half
//     o_valid      out  output vector valid
//     o_Y          out  NUM_LANES packed results
//
//   Flow control: there is no back-pressure. A vector is taken whenever
//   i_valid=1 and i_en=1 at a rising edge; o_valid is not a handshake, the
//   consumer must take o_Y at every edge where o_valid=1 and i_en=1.
interface n3_pwl_array_if #(
  parameter int BIT_WIDTH = 16,
  parameter int SEG_BITS  = 4,
  parameter int NUM_LANES = 16
);
  logic                           i_en;
  logic                           i_valid;
  logic [1:0]                     i_mode;
  logic [NUM_LANES*BIT_WIDTH-1:0] i_X;
  logic                           i_load_coef;
  logic [SEG_BITS-1:0]            i_coef_addr;
  logic [2*BIT_WIDTH-1:0]         i_coef;
  logic                           o_valid;
  logic [NUM_LANES*BIT_WIDTH-1:0] o_Y;

  modport master (
    output i_en, i_valid, i_mode, i_X, i_load_coef, i_coef_addr, i_coef,
    input  o_valid, o_Y
  );

  modport slave (
    input  i_en, i_valid, i_mode, i_X, i_load_coef, i_coef_addr, i_coef,
    output o_valid, o_Y
  );
endinterface

// File: rtl/n3_pwl_array.sv
// n3_pwl_array
//   Multi-lane piecewise-linear activation: y = sat(a[s]*x + b[s]) per lane,
//   with a shared runtime-loadable table of 2^SEG_BITS {a, b} segments, plus
//   identity and ReLU bypass modes. Three registered stages:
//     stage 1: x, mode, valid and the looked-up a/b per lane
//     stage 2: unsaturated result r (2W+1 bits) or the pass-through value
//     stage 3: saturated y (o_Y) and o_valid
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset (table -> identity, pipeline cleared)
//     pwl  n3_pwl_array_if.slave bus (see the interface file)
module n3_pwl_array #(
  parameter int BIT_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int SEG_BITS  = 4,
  parameter int NUM_LANES = 16
) (
  input logic           clk,
  input logic           rst,
  n3_pwl_array_if.slave pwl
);

  localparam int W    = BIT_WIDTH;
  localparam int NSEG = 1 << SEG_BITS;
  localparam int RW   = 2 * W + 1;

  // Flipping the top bit of the signed slice gives an offset-binary index:
  // most negative x -> segment 0, most positive -> segment NSEG-1.
  localparam logic [SEG_BITS-1:0] SEG_FLIP = SEG_BITS'(1) << (SEG_BITS - 1);
  localparam logic [W-1:0]        COEF_ONE = W'(1) << FRAC_BITS;
  localparam logic [1:0]          MODE_ID   = 2'd1;
  localparam logic [1:0]          MODE_RELU = 2'd2;

  // ---------------------------------------------------------------------------
  // Coefficient table: one write port, NUM_LANES read ports. Writes ignore
  // i_en; a lookup in the cycle of a write sees the old entry because stage 1
  // samples the registers before the edge updates them.
  // ---------------------------------------------------------------------------
  logic [W-1:0] coef_a_q [NSEG];
  logic [W-1:0] coef_b_q [NSEG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) begin
        coef_a_q[i] <= COEF_ONE;
        coef_b_q[i] <= '0;
      end
    end else if (pwl.i_load_coef) begin
      coef_a_q[pwl.i_coef_addr] <= pwl.i_coef[2*W-1:W];
      coef_b_q[pwl.i_coef_addr] <= pwl.i_coef[W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: lane split, segment lookup
  // ---------------------------------------------------------------------------
  logic [W-1:0]        s1_x_d  [NUM_LANES];
  logic [SEG_BITS-1:0] seg_idx [NUM_LANES];
  logic [W-1:0]        s1_a_d  [NUM_LANES];
  logic [W-1:0]        s1_b_d  [NUM_LANES];

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      s1_x_d[k]  = pwl.i_X[k*W +: W];
      seg_idx[k] = pwl.i_X[k*W + W - 1 -: SEG_BITS] ^ SEG_FLIP;
      s1_a_d[k]  = coef_a_q[seg_idx[k]];
      s1_b_d[k]  = coef_b_q[seg_idx[k]];
    end
  end

  logic         s1_valid_q;
  logic [1:0]   s1_mode_q;
  logic [W-1:0] s1_x_q [NUM_LANES];
  logic [W-1:0] s1_a_q [NUM_LANES];
  logic [W-1:0] s1_b_q [NUM_LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        s1_x_q[k] <= '0;
        s1_a_q[k] <= '0;
        s1_b_q[k] <= '0;
      end
    end else if (pwl.i_en) begin
      s1_valid_q <= pwl.i_valid;
      // Data only loads for real vectors so bubbles leave it untouched.
      if (pwl.i_valid) begin
        s1_mode_q <= pwl.i_mode;
        for (int k = 0; k < NUM_LANES; k++) begin
          s1_x_q[k] <= s1_x_d[k];
          s1_a_q[k] <= s1_a_d[k];
          s1_b_q[k] <= s1_b_d[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: multiply, shift, add bias (or pass-through), all at 2W+1 bits so
  // nothing can wrap before saturation.
  // ---------------------------------------------------------------------------
  logic signed [2*W-1:0] prod    [NUM_LANES];
  logic signed [2*W-1:0] prod_sh [NUM_LANES];
  logic [RW-1:0]         s2_r_d  [NUM_LANES];

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      // Operands sign-extended to 2W so the low 2W product bits are exact.
      prod[k]    = $signed({{W{s1_x_q[k][W-1]}}, s1_x_q[k]}) *
                   $signed({{W{s1_a_q[k][W-1]}}, s1_a_q[k]});
      prod_sh[k] = prod[k] >>> FRAC_BITS;
      case (s1_mode_q)
        MODE_ID:   s2_r_d[k] = {{(W+1){s1_x_q[k][W-1]}}, s1_x_q[k]};
        MODE_RELU: s2_r_d[k] = s1_x_q[k][W-1] ? '0 : {{(W+1){1'b0}}, s1_x_q[k]};
        default:   s2_r_d[k] = {prod_sh[k][2*W-1], prod_sh[k]} +
                               {{(W+1){s1_b_q[k][W-1]}}, s1_b_q[k]};
      endcase
    end
  end

  logic          s2_valid_q;
  logic [RW-1:0] s2_r_q [NUM_LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) s2_r_q[k] <= '0;
    end else if (pwl.i_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        for (int k = 0; k < NUM_LANES; k++) s2_r_q[k] <= s2_r_d[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: saturate to W bits. r fits when its bits [RW-1:W-1] are all equal.
  // ---------------------------------------------------------------------------
  logic [NUM_LANES*W-1:0] y_d;

  always_comb begin
    y_d = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if ((&s2_r_q[k][RW-1:W-1]) || !(|s2_r_q[k][RW-1:W-1])) begin
        y_d[k*W +: W] = s2_r_q[k][W-1:0];
      end else if (s2_r_q[k][RW-1]) begin
        y_d[k*W +: W] = {1'b1, {(W-1){1'b0}}};
      end else begin
        y_d[k*W +: W] = {1'b0, {(W-1){1'b1}}};
      end
    end
  end

  logic                   o_valid_q;
  logic [NUM_LANES*W-1:0] y_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      y_q       <= '0;
    end else if (pwl.i_en) begin
      o_valid_q <= s2_valid_q;
      if (s2_valid_q) y_q <= y_d;
    end
  end

  assign pwl.o_valid = o_valid_q;
  assign pwl.o_Y     = y_q;

endmodule

// File: tb/tb_n3_pwl_array.sv
// tb_n3_pwl_array
//   Directed scenarios followed by randomized traffic against an arithmetic
//   reference model. The driver pushes expected output vectors into exp_q at
//   capture time; an independent monitor pops and compares whenever a new
//   output appears, and checks that outputs hold during stalls.
module tb_n3_pwl_array;
  localparam int W    = 16;
  localparam int F    = 8;
  localparam int SB   = 4;
  localparam int NL   = 16;
  localparam int LW   = NL * W;
  localparam int NSEG = 1 << SB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  n3_pwl_array_if #(.BIT_WIDTH(W), .SEG_BITS(SB), .NUM_LANES(NL)) pwl();

  n3_pwl_array #(
    .BIT_WIDTH(W), .FRAC_BITS(F), .SEG_BITS(SB), .NUM_LANES(NL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pwl(pwl)
  );

  // ---------------- scoreboard state ----------------
  logic [LW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int tab_a [NSEG];
  int tab_b [NSEG];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < NSEG; i++) begin
      tab_a[i] = 1 << F;
      tab_b[i] = 0;
    end
  endfunction

  function automatic logic [LW-1:0] model(input logic [1:0] mode, input logic [LW-1:0] x);
    logic [LW-1:0] y;
    longint maxv;
    longint minv;
    maxv = (longint'(1) << (W - 1)) - 1;
    minv = -(longint'(1) << (W - 1));
    y = '0;
    for (int k = 0; k < NL; k++) begin
      logic signed [W-1:0] xs;
      longint xi;
      longint r;
      int seg;
      xs = x[k*W +: W];
      xi = xs;
      if (mode == 2'd1) begin
        r = xi;
      end else if (mode == 2'd2) begin
        r = (xi < 0) ? 0 : xi;
      end else begin
        // floor(x / 2^(W-SB)) shifted into the range 0 .. NSEG-1
        seg = int'(xi >>> (W - SB)) + NSEG / 2;
        r = ((xi * longint'(tab_a[seg])) >>> F) + longint'(tab_b[seg]);
      end
      if (r > maxv) r = maxv;
      if (r < minv) r = minv;
      y[k*W +: W] = r[W-1:0];
    end
    return y;
  endfunction

  function automatic logic [LW-1:0] splat(input logic [W-1:0] v);
    return {NL{v}};
  endfunction

  function automatic logic [LW-1:0] rand_vec();
    logic [LW-1:0] v;
    for (int k = 0; k < NL; k++) v[k*W +: W] = W'($urandom);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs are applied 1 time unit after a rising edge and captured at the next.
  task automatic drive(input logic en, input logic vld, input logic [1:0] mode,
                       input logic [LW-1:0] x, input logic ld, input logic [SB-1:0] addr,
                       input logic [2*W-1:0] coef, input logic fix, input logic [LW-1:0] fexp);
    logic signed [W-1:0] ca;
    logic signed [W-1:0] cb;
    pwl.i_en        = en;
    pwl.i_valid     = vld;
    pwl.i_mode      = mode;
    pwl.i_X         = x;
    pwl.i_load_coef = ld;
    pwl.i_coef_addr = addr;
    pwl.i_coef      = coef;
    // Expected value uses the table as it stands before this edge's write.
    if (en && vld) exp_q.push_back(fix ? fexp : model(mode, x));
    if (ld) begin
      ca = coef[2*W-1:W];
      cb = coef[W-1:0];
      tab_a[addr] = ca;
      tab_b[addr] = cb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 2'd0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic vec(input logic [1:0] mode, input logic [LW-1:0] x);
    drive(1'b1, 1'b1, mode, x, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic vec_fix(input logic [1:0] mode, input logic [LW-1:0] x, input logic [LW-1:0] e);
    drive(1'b1, 1'b1, mode, x, 1'b0, '0, '0, 1'b1, e);
  endtask

  task automatic load(input logic [SB-1:0] addr, input logic [W-1:0] a, input logic [W-1:0] b);
    drive(1'b1, 1'b0, 2'd0, '0, 1'b1, addr, {a, b}, 1'b0, '0);
  endtask

  // ---------------- monitor ----------------
  // 0: no edge / reset, 1: advancing edge, 2: stalled edge
  int            edge_kind = 0;
  logic          prev_v;
  logic [LW-1:0] prev_y;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_kind <= 0;
    else     edge_kind <= pwl.i_en ? 1 : 2;
  end

  always @(negedge clk) begin
    if (edge_kind == 2) begin
      check("stall_valid", LW'(pwl.o_valid), LW'(prev_v));
      check("stall_y", pwl.o_Y, prev_y);
    end else if (edge_kind == 1 && pwl.o_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out actual=%h required=no_output", pwl.o_Y);
      end else begin
        check("out_y", pwl.o_Y, exp_q.pop_front());
      end
    end
    prev_v = pwl.o_valid;
    prev_y = pwl.o_Y;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    pwl.i_en = 1'b0;
    pwl.i_valid = 1'b0;
    pwl.i_mode = '0;
    pwl.i_X = '0;
    pwl.i_load_coef = 1'b0;
    pwl.i_coef_addr = '0;
    pwl.i_coef = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", LW'(pwl.o_valid), '0);
    check("reset_y", pwl.o_Y, '0);
    rst = 1'b0;

    // Identity table after reset, plus latency in edges
    vec_fix(2'd0, splat(16'h0180), splat(16'h0180));
    @(negedge clk); check("lat_edge_t", LW'(pwl.o_valid), '0);
    idle();
    @(negedge clk); check("lat_edge_t1", LW'(pwl.o_valid), '0);
    idle();
    @(negedge clk); check("lat_edge_t2", LW'(pwl.o_valid), LW'(1'b1));

    // Loaded segments
    load(4'd8, 16'h0080, 16'h0040);
    vec_fix(2'd0, splat(16'h0100), splat(16'h00C0));
    load(4'd7, 16'h0200, 16'hFF00);
    vec_fix(2'd0, splat(16'hFF00), splat(16'hFD00));

    // Saturation both directions
    load(4'd8, 16'h7FFF, 16'h0000);
    vec_fix(2'd0, splat(16'h0700), splat(16'h7FFF));
    load(4'd7, 16'h7FFF, 16'h0000);
    vec_fix(2'd0, splat(16'hF900), splat(16'h8000));

    // Modes, including back-to-back alternation
    vec_fix(2'd2, splat(16'hFF00), splat(16'h0000));
    vec_fix(2'd1, splat(16'hFF00), splat(16'hFF00));
    for (int i = 0; i < 8; i++) vec(2'(i % 4), rand_vec());
    repeat (3) idle();

    // Write/lookup collision on segment 8: old entry for this vector, new next
    load(4'd8, 16'h0080, 16'h0040);
    drive(1'b1, 1'b1, 2'd0, splat(16'h0100), 1'b1, 4'd8, {16'h0100, 16'h0100},
          1'b1, splat(16'h00C0));
    vec_fix(2'd0, splat(16'h0100), splat(16'h0200));

    // Stall mid-stream; inputs offered during the stall must be ignored and a
    // table write during the stall must not affect captured data.
    vec(2'd0, splat(16'h0100));
    vec(2'd3, rand_vec());
    vec(2'd1, rand_vec());
    drive(1'b0, 1'b1, 2'd0, rand_vec(), 1'b1, 4'd8, {16'h0300, 16'h0010}, 1'b0, '0);
    repeat (3) drive(1'b0, 1'b1, 2'($urandom_range(0, 3)), rand_vec(), 1'b0, '0, '0, 1'b0, '0);
    vec(2'd0, splat(16'h0100));
    vec(2'd2, rand_vec());
    vec(2'd0, rand_vec());
    repeat (4) idle();

    // Reset with three vectors in flight
    vec(2'd0, rand_vec());
    vec(2'd0, rand_vec());
    vec(2'd1, rand_vec());
    rst = 1'b1;
    pwl.i_valid = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check("midrst_valid", LW'(pwl.o_valid), '0);
    check("midrst_y", pwl.o_Y, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    idle();
    vec_fix(2'd0, splat(16'h0100), splat(16'h0100));
    repeat (4) idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ra = $urandom_range(0, 1) ? W'($urandom) : W'($urandom_range(0, 1023)) - W'(512);
      rb = $urandom_range(0, 1) ? W'($urandom) : W'($urandom_range(0, 1023)) - W'(512);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            rand_vec(), $urandom_range(0, 7) == 0, SB'($urandom_range(0, NSEG - 1)),
            {ra, rb}, 1'b0, '0);
    end
    repeat (5) idle();
    check("drain", LW'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
